// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dm_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
);
  logic          M0_REQ;
  logic          M0_WE;
  logic          M0_LOCK;
  logic [AW-1:0] M0_ADDR;
  logic [DW-1:0] M0_WDATA;
  logic          M0_GNT;
  logic [DW-1:0] M0_RDATA;
  logic          M0_RVALID;

  logic          M1_REQ;
  logic          M1_WE;
  logic          M1_LOCK;
  logic [AW-1:0] M1_ADDR;
  logic [DW-1:0] M1_WDATA;
  logic          M1_GNT;
  logic [DW-1:0] M1_RDATA;
  logic          M1_RVALID;

  logic          DM_EN;
  logic [AW-1:0] DM_ADDR;
  logic [DW-1:0] DM_IN;
  logic [DW-1:0] DM_OUT;

  modport slave (
    input  M0_REQ, M0_WE, M0_LOCK, M0_ADDR, M0_WDATA,
    output M0_GNT, M0_RDATA, M0_RVALID,
    input  M1_REQ, M1_WE, M1_LOCK, M1_ADDR, M1_WDATA,
    output M1_GNT, M1_RDATA, M1_RVALID,
    output DM_EN, DM_ADDR, DM_IN,
    input  DM_OUT
  );

  modport master (
    output M0_REQ, M0_WE, M0_LOCK, M0_ADDR, M0_WDATA,
    input  M0_GNT, M0_RDATA, M0_RVALID,
    output M1_REQ, M1_WE, M1_LOCK, M1_ADDR, M1_WDATA,
    input  M1_GNT, M1_RDATA, M1_RVALID,
    input  DM_EN, DM_ADDR, DM_IN,
    output DM_OUT
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory, with locked bursts
// bounded by MAX_LOCK consecutive grants while the other port is waiting.
module dm_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic         CLK,
  input  logic         RST,
  dm_arbiter_if.slave  bus
);
  localparam logic [3:0] LockMax = 4'(MAX_LOCK);

  logic          r_last;
  logic          r_own_vld;
  logic          r_own;
  logic [3:0]    r_lcnt;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_rvalid0;
  logic          r_rvalid1;

  logic          w_own_req;
  logic          w_oth_req;
  logic          w_hold;
  logic          w_gnt_vld;
  logic          w_gnt_sel;
  logic          w_we;
  logic          w_lock;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_rd0;
  logic          w_rd1;

  always_comb begin
    w_own_req = r_own ? bus.M1_REQ : bus.M0_REQ;
    w_oth_req = r_own ? bus.M0_REQ : bus.M1_REQ;
    // The owner keeps the grant unless it has used up its quota and the other port waits.
    w_hold    = r_own_vld && w_own_req && !(w_oth_req && (r_lcnt == LockMax));
    w_gnt_vld = RST && (bus.M0_REQ || bus.M1_REQ);
    if (w_hold) begin
      w_gnt_sel = r_own;
    end else if (bus.M0_REQ && bus.M1_REQ) begin
      w_gnt_sel = ~r_last;
    end else begin
      w_gnt_sel = bus.M1_REQ;
    end
    w_we    = w_gnt_sel ? bus.M1_WE    : bus.M0_WE;
    w_lock  = w_gnt_sel ? bus.M1_LOCK  : bus.M0_LOCK;
    w_addr  = w_gnt_sel ? bus.M1_ADDR  : bus.M0_ADDR;
    w_wdata = w_gnt_sel ? bus.M1_WDATA : bus.M0_WDATA;
    w_rd0   = w_gnt_vld && !w_gnt_sel && !w_we;
    w_rd1   = w_gnt_vld && w_gnt_sel && !w_we;
  end

  assign bus.M0_GNT    = w_gnt_vld && !w_gnt_sel;
  assign bus.M1_GNT    = w_gnt_vld && w_gnt_sel;
  assign bus.DM_EN     = w_gnt_vld && w_we;
  assign bus.DM_ADDR   = w_gnt_vld ? w_addr : '0;
  assign bus.DM_IN     = w_gnt_vld ? w_wdata : '0;
  assign bus.M0_RDATA  = r_rdata0;
  assign bus.M1_RDATA  = r_rdata1;
  assign bus.M0_RVALID = r_rvalid0;
  assign bus.M1_RVALID = r_rvalid1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_last    <= 1'b1;
      r_own_vld <= 1'b0;
      r_own     <= 1'b0;
      r_lcnt    <= 4'd0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0) r_rdata0 <= bus.DM_OUT;
      if (w_rd1) r_rdata1 <= bus.DM_OUT;
      if (w_gnt_vld) begin
        r_last <= w_gnt_sel;
        if (w_lock) begin
          r_own_vld <= 1'b1;
          r_own     <= w_gnt_sel;
          if (r_own_vld && (r_own == w_gnt_sel)) begin
            if (r_lcnt != LockMax) r_lcnt <= r_lcnt + 4'd1;
          end else begin
            r_lcnt <= 4'd1;
          end
        end else begin
          r_own_vld <= 1'b0;
          r_lcnt    <= 4'd0;
        end
      end else begin
        r_own_vld <= 1'b0;
        r_lcnt    <= 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a rule-level model of arbitration and memory.
module tb_dm_arbiter;
  localparam int AW       = 10;
  localparam int DW       = 8;
  localparam int MAX_LOCK = 4;
  localparam int DEPTH    = 1 << AW;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Memory attached to the DUT: combinational read, write on the clock edge.
  logic [DW-1:0] mem [DEPTH];
  logic          mem_clr = 1'b1;
  int            wr_count = 0;
  assign bus.DM_OUT = mem[bus.DM_ADDR];
  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.DM_EN) begin
      mem[bus.DM_ADDR] <= bus.DM_IN;
      wr_count <= wr_count + 1;
    end
  end

  // Requester state (held until granted).
  bit            req [2];
  bit            we  [2];
  bit            lock[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wd  [2];

  // Reference model.
  int            m_last, m_owner, m_lcnt;
  logic [DW-1:0] m_mem  [DEPTH];
  logic [DW-1:0] m_rdata[2];
  bit            m_rvalid[2];

  int checks = 0;
  int errors = 0;

  // Observed DUT values of the most recent step.
  int            a_g;
  logic          a_en, a_rv0, a_rv1;
  logic [DW-1:0] a_rd0, a_rd1;
  int            mg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (!RST) return -1;
    if (m_owner >= 0 && req[m_owner] && !(req[1-m_owner] && m_lcnt == MAX_LOCK)) return m_owner;
    if (req[0] && req[1]) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 1; m_owner = -1; m_lcnt = 0;
    m_rvalid[0] = 0; m_rvalid[1] = 0;
    m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  task automatic apply();
    bus.M0_REQ = req[0]; bus.M0_WE = we[0]; bus.M0_LOCK = lock[0];
    bus.M0_ADDR = addr[0]; bus.M0_WDATA = wd[0];
    bus.M1_REQ = req[1]; bus.M1_WE = we[1]; bus.M1_LOCK = lock[1];
    bus.M1_ADDR = addr[1]; bus.M1_WDATA = wd[1];
  endtask

  // One clock: drive at negedge, check grant/memory side, model the edge, check responses.
  task automatic step();
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    @(negedge CLK);
    apply();
    #1;
    mg = model_grant();
    e_en = 1'b0; e_addr = '0; e_din = '0;
    if (mg >= 0) begin
      e_en = we[mg]; e_addr = addr[mg]; e_din = wd[mg];
    end
    a_g  = (bus.M0_GNT && bus.M1_GNT) ? 2 : bus.M0_GNT ? 0 : bus.M1_GNT ? 1 : -1;
    a_en = bus.DM_EN;
    chk("m0_gnt", 32'(bus.M0_GNT), 32'(mg == 0));
    chk("m1_gnt", 32'(bus.M1_GNT), 32'(mg == 1));
    chk("dm_en", 32'(bus.DM_EN), 32'(e_en));
    chk("dm_addr", 32'(bus.DM_ADDR), 32'(e_addr));
    chk("dm_in", 32'(bus.DM_IN), 32'(e_din));
    @(posedge CLK);
    if (RST) begin
      m_rvalid[0] = 0; m_rvalid[1] = 0;
      if (mg >= 0) begin
        if (we[mg]) begin
          m_mem[addr[mg]] = wd[mg];
        end else begin
          m_rdata[mg] = m_mem[addr[mg]]; m_rvalid[mg] = 1;
        end
        m_last = mg;
        if (lock[mg]) begin
          m_lcnt  = (m_owner == mg) ? ((m_lcnt + 1 > MAX_LOCK) ? MAX_LOCK : m_lcnt + 1) : 1;
          m_owner = mg;
        end else begin
          m_owner = -1; m_lcnt = 0;
        end
      end else begin
        m_owner = -1; m_lcnt = 0;
      end
    end
    #1;
    a_rv0 = bus.M0_RVALID; a_rv1 = bus.M1_RVALID;
    a_rd0 = bus.M0_RDATA;  a_rd1 = bus.M1_RDATA;
    chk("m0_rvalid", 32'(a_rv0), 32'(m_rvalid[0]));
    chk("m1_rvalid", 32'(a_rv1), 32'(m_rvalid[1]));
    chk("m0_rdata", 32'(a_rd0), 32'(m_rdata[0]));
    chk("m1_rdata", 32'(a_rd1), 32'(m_rdata[1]));
  endtask

  task automatic reset_pulse();
    RST = 1'b0;
    model_reset();
    step();
    RST = 1'b1;
  endtask

  task automatic set_req(input int p, input bit r, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = r; we[p] = w; lock[p] = l; addr[p] = a; wd[p] = d;
  endtask

  task automatic new_req(input int p);
    req[p]  = 1;
    we[p]   = 1'($urandom_range(0, 1));
    lock[p] = ($urandom_range(0, 2) == 0);
    addr[p] = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    wd[p]   = DW'($urandom);
  endtask

  int  snap;
  bit  found;
  int  exp_seq[6];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);

    // Reset holds everything off even with a write pending.
    set_req(0, 1, 1, 0, 10'h010, 8'h11);
    step();
    mem_clr = 1'b0;
    chk("rst_m0_gnt", 32'(a_g), 32'(-1));
    chk("rst_dm_en", 32'(a_en), 32'(0));
    chk("rst_m0_rvalid", 32'(a_rv0), 32'(0));
    RST = 1'b1;
    step();
    chk("first_gnt_after_rst", 32'(a_g), 32'(0));

    // Write then read back the top address.
    set_req(0, 1, 1, 0, 10'h3FF, 8'hA5);
    step();
    chk("wr_gnt", 32'(a_g), 32'(0));
    chk("wr_no_rvalid", 32'(a_rv0), 32'(0));
    set_req(0, 1, 0, 0, 10'h3FF, 8'h00);
    step();
    chk("rd_gnt", 32'(a_g), 32'(0));
    chk("rd_rvalid", 32'(a_rv0), 32'(1));
    chk("rd_rdata", 32'(a_rd0), 32'(8'hA5));
    set_req(0, 0, 0, 0, '0, '0);
    step();
    chk("rvalid_one_pulse", 32'(a_rv0), 32'(0));
    chk("rdata_held", 32'(a_rd0), 32'(8'hA5));

    // Unlocked contention alternates, port 0 first after reset.
    reset_pulse();
    set_req(0, 1, 0, 0, 10'h3FF, 8'h00);
    set_req(1, 1, 0, 0, 10'h010, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_gnt", 32'(a_g), 32'(i % 2));
      chk("alt_rv0", 32'(a_rv0), 32'(i % 2 == 0));
      chk("alt_rv1", 32'(a_rv1), 32'(i % 2 == 1));
    end

    // Locked burst on port 1 yields to port 0 after MAX_LOCK grants.
    reset_pulse();
    set_req(0, 0, 0, 0, 10'h3FF, 8'h00);
    set_req(1, 1, 0, 1, 10'h020, 8'h00);
    exp_seq = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      if (i == 1) req[0] = 1;
      step();
      chk("burst_gnt", 32'(a_g), 32'(exp_seq[i]));
    end

    // Lone locked requester keeps the grant; the other gets in within MAX_LOCK+1.
    req[0] = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("lone_lock_gnt", 32'(a_g), 32'(1));
    end
    req[0] = 1;
    found = 0;
    for (int i = 0; i < MAX_LOCK + 1 && !found; i++) begin
      step();
      if (a_g == 0) found = 1;
    end
    chk("lone_lock_yield", 32'(found), 32'(1));

    // Reset in the middle of a locked write burst.
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    reset_pulse();
    snap = wr_count;
    set_req(1, 1, 1, 1, 10'h100, 8'h31);
    step();
    set_req(1, 1, 1, 1, 10'h101, 8'h32);
    step();
    set_req(1, 1, 1, 1, 10'h102, 8'h33);
    RST = 1'b0;
    model_reset();
    step();
    RST = 1'b1;
    chk("rst_burst_writes", 32'(wr_count - snap), 32'(2));
    set_req(0, 1, 0, 0, 10'h102, 8'h00);
    step();
    chk("rst_burst_tie_p0", 32'(a_g), 32'(0));
    chk("rst_burst_no_third", 32'(a_rd0), 32'(8'h00));
    set_req(0, 1, 0, 0, 10'h101, 8'h00);
    step();
    chk("rst_burst_p1_resumes", 32'(a_g), 32'(1));
    req[1] = 0;
    step();
    chk("rst_burst_second", 32'(a_rd0), 32'(8'h32));
    req[0] = 0;

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        RST = 1'b0;
        model_reset();
        step();
        RST = 1'b1;
      end else begin
        step();
      end
      for (int p = 0; p < 2; p++) begin
        if (mg == p) begin
          if ($urandom_range(0, 2) != 0) new_req(p);
          else req[p] = 0;
        end else if (!req[p] && $urandom_range(0, 3) == 0) begin
          new_req(p);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port round-robin arbiter that shares the single-port 1024x8 data memory between two requesters: port 0 is the core load/store path and port 1 is a loader/DMA path.
- Drives the memory's enable, address and write-data inputs.
- Samples the memory's combinational read output and returns it to the granted requester as a registered response.
- Supports short locked bursts, bounded by a fairness limit.

Parameters:
- AW, 10, memory address width.
- DW, 8, data width.
- MAX_LOCK, 4, max consecutive grants to one requester while the other is requesting (range 1..15).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- M0_REQ  in  1  port 0 access request.
- M0_WE  in  1  port 0 write (1) / read (0).
- M0_LOCK  in  1  port 0 asks to keep the grant next cycle.
- M0_ADDR  in  AW  port 0 address.
- M0_WDATA  in  DW  port 0 write data.
- M0_GNT  out  1  port 0 access performed this cycle.
- M0_RDATA  out  DW  port 0 read data.
- M0_RVALID  out  1  M0_RDATA valid (one-cycle pulse).
- M1_REQ, M1_WE, M1_LOCK, M1_ADDR, M1_WDATA, M1_GNT, M1_RDATA, M1_RVALID: same as port 0, for port 1.
- DM_EN  out  1  memory write enable.
- DM_ADDR  out  AW  memory address.
- DM_IN  out  DW  memory write data.
- DM_OUT  in  DW  memory combinational read data.

Behaviour:
- Reset (RST=0, async):
  - LAST=1, so port 0 wins the first tie; OWNER=none; LCNT=0.
  - M*_RDATA=0, M*_RVALID=0.
  - While RST=0, M*_GNT=0, DM_EN=0, DM_ADDR=0, DM_IN=0.
- Grant selection (combinational from current REQs and registered LAST/OWNER/LCNT):
  - Lock hold: if OWNER=p and Mp_REQ=1, grant p, unless the other port requests and LCNT==MAX_LOCK.
  - Otherwise a single requester gets the grant.
  - With both requesting, the port != LAST wins.
  - No requests: no grant, DM_EN=0, DM_ADDR=0, DM_IN=0.
- Access:
  - Granted port g drives DM_ADDR=Mg_ADDR, DM_IN=Mg_WDATA, DM_EN=Mg_WE.
  - Mg_GNT=1 in the same cycle. The access completes at the next rising edge.
  - Requesters hold REQ and fields stable until they sample GNT=1 at an edge.
- Read response:
  - For a granted read, DM_OUT is registered at the edge.
  - Mg_RDATA=DM_OUT, Mg_RVALID=1 for exactly one cycle.
  - Latency is 1 cycle after GNT.
- Write response:
  - No RVALID is produced.
  - Mg_RDATA holds its previous value.
  - A write and a read to the same address in consecutive cycles return the new data.
- Registered updates at each edge with grant g:
  - LAST=g.
  - If Mg_LOCK=1: OWNER=g, and LCNT=LCNT+1 if OWNER was already g, else 1 (saturates at MAX_LOCK).
  - If Mg_LOCK=0: OWNER=none, LCNT=0.
- No grant at the edge: OWNER=none, LCNT=0, LAST unchanged.
- Forced yield: when LCNT==MAX_LOCK and the other port requests, the other port is granted; OWNER and LCNT are then recomputed for it.
- Lock without contention: a lone locked requester keeps the grant indefinitely; LCNT saturates.
- Simultaneous REQ on both ports with neither owning: strict alternation on consecutive cycles.
- Address width: DM_ADDR is AW bits with no wrap logic; out-of-range is impossible.
- Reset mid-burst: OWNER and LCNT cleared, pending RVALID dropped, and no write issued while RST=0.

Test Plan:
- Reset check: assert RST=0 with M0_REQ=1, M0_WE=1 -> DM_EN=0, M0_GNT=0, M0_RVALID=0. Release reset -> M0 granted in the first cycle.
- Write then read: M0 writes 0xA5 to 0x3FF. Next cycle, M0 reads 0x3FF -> M0_GNT=1 both cycles; M0_RVALID=1 with M0_RDATA=0xA5 one cycle after the read grant.
- Contention, no lock: M0 and M1 both request reads continuously -> grants alternate 0,1,0,1 (port 0 first after reset); each RVALID pulses one cycle after its own grant.
- Locked burst fairness, MAX_LOCK=4: M1 holds LOCK=1 and REQ, with grant first; M0 requests from cycle 1 -> M1 granted 4 consecutive cycles, then M0 granted, then M1 again.
- Lone lock: only M1 requests with LOCK=1 for 20 cycles -> M1_GNT=1 all 20 cycles; M0 then requests -> M0 granted within MAX_LOCK+1 cycles.
- Reset mid-burst: M1 locked burst of 3 writes; RST pulsed low after the 2nd -> only 2 memory writes occur; after release, LCNT=0 and port 0 wins a tie.
